// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake and instruction-memory write bus for the program loader.
// The slave modport is the loader's view; the master modport is the producer/memory side.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic [3:0]        in_rs;
    logic [3:0]        in_rt;
    logic [3:0]        in_rd;
    logic [7:0]        in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport slave (
        input  in_valid, in_opcode, in_rs, in_rt, in_rd, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_opcode, in_rs, in_rt, in_rd, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs opcode/register/immediate bundles into 16-bit instructions and writes them
// sequentially into instruction memory from a latched base address.
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    instr_encoder_loader_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [ADDR_W:0]      count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
        S_DONE   = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [1:0]        ERR_NONE     = 2'd0;
    localparam logic [1:0]        ERR_IMM      = 2'd1;
    localparam logic [1:0]        ERR_OVERFLOW = 2'd2;

    // Opcodes 7 and above carry a 4-bit immediate in place of rd.
    function automatic logic [15:0] encode_word(
        input logic [3:0] op,
        input logic [3:0] rs,
        input logic [3:0] rt,
        input logic [3:0] rd,
        input logic [3:0] imm_lo
    );
        logic [15:0] word;
        if (op >= 4'd7) begin
            word = {op, rs, rt, imm_lo};
        end else begin
            word = {op, rs, rt, rd};
        end
        return word;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              last_q, last_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              imm_bad_s;
    logic [ADDR_W:0]   count_inc_s;

    assign imm_bad_s   = (bus.in_opcode >= 4'd7) && (bus.in_imm[7:4] != 4'd0);
    assign count_inc_s = count_q + CNT_ONE;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        error_d     = error_q;
        err_code_d  = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d      = base_addr;
                    count_d    = '0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    state_d    = S_ACCEPT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCEPT: begin
                if (bus.in_valid && in_ready_q) begin
                    if (imm_bad_s) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_IMM;
                        state_d    = S_ERROR;
                    end else begin
                        mem_addr_d  = ptr_q;
                        mem_wdata_d = encode_word(bus.in_opcode, bus.in_rs, bus.in_rt,
                                                  bus.in_rd, bus.in_imm[3:0]);
                        last_d      = bus.in_last;
                        state_d     = S_WRITE;
                    end
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_WRITE: begin
                ptr_d   = ptr_q + PTR_ONE;
                count_d = count_inc_s;
                // A last marker on the final writable word still ends cleanly.
                if (last_q) begin
                    state_d = S_DONE;
                end else if (count_inc_s == DEPTH_C) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_OVERFLOW;
                    state_d    = S_ERROR;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_ACCEPT);
        mem_we_d   = (state_d == S_WRITE);
        busy_d     = (state_d == S_ACCEPT) || (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
    end

    // State and output registers; reset clears the write strobe without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'h0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign count         = count_q;

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Writer-side counterpart to the CPU's 16-bit instruction decode path.
- Accepts instruction fields (opcode, registers, immediate) over a valid/ready handshake and packs them into the 16-bit instruction format.
- Writes each word sequentially into instruction memory starting at a programmable base address.
- Used by the test/boot infrastructure to load programs before the CPU runs.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of writable words; must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begins a load session; sampled in IDLE only.
- base_addr  input  ADDR_W  first write address; latched on start.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- in_opcode  input  4  opcode.
- in_rs  input  4  source register 1; also the I-type destination.
- in_rt  input  4  source register 2.
- in_rd  input  4  R-type destination.
- in_imm  input  8  immediate; only values 0..15 are encodable.
- in_last  input  1  marks the final instruction of the session.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  16  encoded instruction.
- busy  output  1  session in progress.
- done  output  1  one-cycle pulse when the session ends normally.
- error  output  1  sticky error flag; cleared by the next accepted start.
- err_code  output  2  error cause: 0 none, 1 imm_range, 2 overflow.
- count  output  ADDR_W+1  words written in the current or last session.

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset is asynchronous; it forces mem_we=0 immediately, even mid-write.
- States:
  - IDLE: start=1 latches base_addr into the address pointer, clears count, error and err_code, then goes to ACCEPT. A start in any other state is ignored.
  - ACCEPT: in_ready=1 and busy=1. A transfer occurs when in_valid && in_ready on a rising edge; fields are registered and the block goes to WRITE. If the opcode is I-type and in_imm[7:4]≠0, it goes to ERROR with err_code=1 and no write.
  - WRITE: in_ready=0 and mem_we=1 for exactly one cycle, with mem_addr = pointer and mem_wdata = encoded word. On the following edge:
    - pointer increments, wrapping modulo 2^ADDR_W; count increments.
    - If the registered last=1, go to DONE.
    - Else if count (after increment) = DEPTH, go to ERROR with err_code=2.
    - Else go to ACCEPT.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
  - ERROR: error=1, busy=0, next cycle IDLE. error and err_code hold until the next start.
- Encoding:
  - R-type (opcode < 7): {opcode, rs, rt, rd}; in_imm ignored.
  - I-type (opcode ≥ 7): {opcode, rs, rt, imm[3:0]}; in_rd ignored. Zero-extension is the reader's job.
- Throughput: one word per 2 cycles maximum. Latency from accept edge to mem_we high is 1 cycle.
- in_ready is a registered state decode; it does not depend combinationally on in_valid.
- Overflow takes priority below last: last=1 on the DEPTH-th word ends in DONE, not ERROR.
- Simultaneous start and in_valid in IDLE: start is taken; in_valid is not accepted that cycle.
- mem_addr and mem_wdata are held stable when mem_we=0; their value is don't-care.

Test Plan:
- Reset, start with base_addr=0x10, send R-type op=2 rs=1 rt=2 rd=3 with last=1 -> one cycle of mem_we with addr 0x10 and wdata 0x2123; done pulse; count=1.
- Send I-type op=9 rs=4 rt=5 imm=0x0A, then op=7 rs=1 rt=0 imm=0x0F with last=1 -> writes 0x945A at base, then 0x710F at base+1; done; count=2.
- Send I-type with imm=0x1F -> no mem_we; error=1, err_code=1; the next start clears error.
- With DEPTH=4 and base 0, send 4 words with last=0 -> writes at addr 0..3, then error with err_code=2 and count=4. Repeat with last on the 4th word -> done, no error.
- With base_addr=0xFE, 3 words -> addresses 0xFE, 0xFF, 0x00 (wrap); done.
- Assert reset while in WRITE -> mem_we drops the same cycle, all outputs 0. Assert start while busy -> ignored; the pointer is not reloaded.
